// File: rtl/alarm_timer_bank.sv
// Bank of programmable interval lengths feeding one 1 Hz countdown with an expiry pulse.
// Optional build macro TIMER_PAUSE_EN adds a pause input that freezes the countdown.
module alarm_timer_bank #(
  parameter int unsigned NUM_TIMERS = 4,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned LEN_W      = 4,
  parameter logic [NUM_TIMERS*LEN_W-1:0] DEFAULTS = {4'd10, 4'd15, 4'd8, 4'd6}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reprogram,
  input  logic [SEL_W-1:0] prog_sel,
  input  logic [LEN_W-1:0] prog_len,
  input  logic             start_timer,
  input  logic [SEL_W-1:0] interval_sel,
  input  logic             one_hz_enable,
`ifdef TIMER_PAUSE_EN
  input  logic             pause,
`endif
  output logic [LEN_W-1:0] countdown,
  output logic             busy,
  output logic             expired
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic             expired_q, expired_d;
  logic [LEN_W-1:0] len_tbl_q [NUM_TIMERS];
  logic [LEN_W-1:0] len_tbl_d [NUM_TIMERS];

  logic [LEN_W-1:0] sel_len;
  logic             sel_valid;
  logic             tick_ok;

`ifdef TIMER_PAUSE_EN
  assign tick_ok = one_hz_enable & ~pause;
`else
  assign tick_ok = one_hz_enable;
`endif

  // Decoded read of the pre-edge table; out-of-range selects leave sel_valid low.
  always_comb begin
    sel_len   = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      if (interval_sel == SEL_W'(i)) begin
        sel_len   = len_tbl_q[i];
        sel_valid = 1'b1;
      end
    end
  end

  always_comb begin
    len_tbl_d = len_tbl_q;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      if (reprogram && (prog_sel == SEL_W'(i))) begin
        len_tbl_d[i] = prog_len;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    expired_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_timer) begin
          if (!sel_valid) begin
            count_d = '0;
          end else if (sel_len == '0) begin
            count_d   = '0;
            expired_d = 1'b1;
          end else begin
            count_d = sel_len;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        // A start in the same cycle as a tick wins and suppresses the decrement.
        if (start_timer) begin
          if (!sel_valid) begin
            count_d = '0;
            state_d = StIdle;
          end else if (sel_len == '0) begin
            count_d   = '0;
            state_d   = StIdle;
            expired_d = 1'b1;
          end else begin
            count_d = sel_len;
          end
        end else if (tick_ok) begin
          if (count_q <= LEN_W'(1)) begin
            count_d   = '0;
            state_d   = StIdle;
            expired_d = 1'b1;
          end else begin
            count_d = count_q - LEN_W'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      count_q   <= '0;
      expired_q <= 1'b0;
      for (int i = 0; i < NUM_TIMERS; i++) begin
        len_tbl_q[i] <= DEFAULTS[i*LEN_W +: LEN_W];
      end
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      expired_q <= expired_d;
      len_tbl_q <= len_tbl_d;
    end
  end

  assign countdown = count_q;
  assign busy      = (state_q == StRun);
  assign expired   = expired_q;

endmodule

// File: tb/tb_alarm_timer_bank.sv
// Directed self-checking bench for alarm_timer_bank; expected values are hand-computed.
module tb_alarm_timer_bank;

  logic       clk;
  logic       reset;
  logic       reprogram;
  logic [1:0] prog_sel;
  logic [3:0] prog_len;
  logic       start_timer;
  logic [1:0] interval_sel;
  logic       one_hz_enable;
`ifdef TIMER_PAUSE_EN
  logic       pause;
`endif
  logic [3:0] countdown;
  logic       busy;
  logic       expired;

  int n_cmp;
  int n_bad;

  alarm_timer_bank dut (
    .clk          (clk),
    .reset        (reset),
    .reprogram    (reprogram),
    .prog_sel     (prog_sel),
    .prog_len     (prog_len),
    .start_timer  (start_timer),
    .interval_sel (interval_sel),
    .one_hz_enable(one_hz_enable),
`ifdef TIMER_PAUSE_EN
    .pause        (pause),
`endif
    .countdown    (countdown),
    .busy         (busy),
    .expired      (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int cnt, input int bsy, input int exp_p);
    chk({tag, ".countdown"}, 32'(countdown), 32'(cnt));
    chk({tag, ".busy"}, 32'(busy), 32'(bsy));
    chk({tag, ".expired"}, 32'(expired), 32'(exp_p));
  endtask

  task automatic do_start(input logic [1:0] sel);
    start_timer  = 1'b1;
    interval_sel = sel;
    cyc();
    start_timer  = 1'b0;
  endtask

  task automatic do_tick();
    one_hz_enable = 1'b1;
    cyc();
    one_hz_enable = 1'b0;
  endtask

  task automatic do_reprogram(input logic [1:0] sel, input logic [3:0] len);
    reprogram = 1'b1;
    prog_sel  = sel;
    prog_len  = len;
    cyc();
    reprogram = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    reprogram = 1'b0;
    prog_sel = '0;
    prog_len = '0;
    start_timer = 1'b0;
    interval_sel = '0;
    one_hz_enable = 1'b0;
`ifdef TIMER_PAUSE_EN
    pause = 1'b0;
`endif
    cyc();
    cyc();
    reset = 1'b0;
    chk_all("reset", 0, 0, 0);

    // 1: default entry 0 = 6, count to expiry
    do_start(2'd0);
    chk_all("t1.load", 6, 1, 0);
    for (int k = 5; k >= 0; k--) begin
      do_tick();
      chk_all($sformatf("t1.tick%0d", k), k, (k != 0) ? 1 : 0, (k == 0) ? 1 : 0);
    end
    cyc();
    chk_all("t1.after", 0, 0, 0);
    do_tick();
    chk_all("t1.idle_tick", 0, 0, 0);

    // 2: reprogram entry 2 = 3, then reset restores 15
    do_reprogram(2'd2, 4'd3);
    do_start(2'd2);
    chk_all("t2.load", 3, 1, 0);
    do_tick();
    do_tick();
    chk_all("t2.tick2", 1, 1, 0);
    do_tick();
    chk_all("t2.tick3", 0, 0, 1);
    do_reset();
    chk_all("t2.reset", 0, 0, 0);
    do_start(2'd2);
    chk_all("t2.default", 15, 1, 0);

    // 3: reprogram + start same entry loads old value
    reprogram    = 1'b1;
    prog_sel     = 2'd1;
    prog_len     = 4'd5;
    start_timer  = 1'b1;
    interval_sel = 2'd1;
    cyc();
    reprogram    = 1'b0;
    start_timer  = 1'b0;
    chk_all("t3.old", 8, 1, 0);
    do_start(2'd1);
    chk_all("t3.new", 5, 1, 0);

    // 4: retrigger while running; start beats a same-cycle tick
    do_start(2'd3);
    chk_all("t4.load", 10, 1, 0);
    for (int k = 0; k < 4; k++) do_tick();
    chk_all("t4.ticked", 6, 1, 0);
    do_start(2'd1);
    chk_all("t4.retrig", 5, 1, 0);
    start_timer   = 1'b1;
    interval_sel  = 2'd3;
    one_hz_enable = 1'b1;
    cyc();
    start_timer   = 1'b0;
    one_hz_enable = 1'b0;
    chk_all("t4.tick_start", 10, 1, 0);
    do_tick();
    chk_all("t4.tick_after", 9, 1, 0);

    // 5: zero-length start, then reset mid-count
    do_reprogram(2'd0, 4'd0);
    do_start(2'd0);
    chk_all("t5.zero", 0, 0, 1);
    cyc();
    chk_all("t5.zero_next", 0, 0, 0);
    do_start(2'd3);
    for (int k = 0; k < 6; k++) do_tick();
    chk_all("t5.at4", 4, 1, 0);
    do_reset();
    chk_all("t5.reset", 0, 0, 0);
    cyc();
    chk_all("t5.reset_next", 0, 0, 0);
    do_start(2'd0);
    chk_all("t5.restored", 6, 1, 0);

`ifdef TIMER_PAUSE_EN
    // 6: pause freezes ticks
    do_reset();
    do_start(2'd1);
    pause = 1'b1;
    for (int k = 0; k < 3; k++) do_tick();
    chk_all("t6.paused", 8, 1, 0);
    pause = 1'b0;
    for (int k = 0; k < 7; k++) do_tick();
    chk_all("t6.tick7", 1, 1, 0);
    do_tick();
    chk_all("t6.tick8", 0, 0, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
